// File: rtl/tlb_refill_ptw_pkg.sv
// tlb_refill_ptw_pkg
// Shared definitions for the TLB refill page-table walker: Sv32-style
// address field widths, PTE bit positions and the walker state encoding.
// Optional feature macro used by the walker files: TLB_PTW_SUPERPAGE_EN
// (accept 4 MiB leaves at level 1).
package tlb_refill_ptw_pkg;

    localparam int VPN_WIDTH        = 10;
    localparam int PPN_WIDTH        = 20;
    localparam int PAGE_OFFSET_BITS = 12;

    // PTE flag bit indices
    localparam int PTE_V = 0;
    localparam int PTE_R = 1;
    localparam int PTE_W = 2;
    localparam int PTE_X = 3;

    // PTE physical page number field
    localparam int PTE_PPN_LSB = 10;
    localparam int PTE_PPN_MSB = 29;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_L1_REQ  = 3'd1,
        ST_L1_WAIT = 3'd2,
        ST_L0_REQ  = 3'd3,
        ST_L0_WAIT = 3'd4,
        ST_FILL    = 3'd5,
        ST_RESP    = 3'd6
    } ptw_state_e;

endpackage

// File: rtl/tlb_refill_ptw_pte_decode.sv
// ptw_pte_decode
// Purely combinational PTE classifier for one level of the walk.
// Ports:
//   pte      - PTE word returned by memory
//   level_l1 - 1 when the PTE came from the level-1 (root) table
//   vpn0     - low VPN of the walked address (used for megapage slicing)
//   leaf     - PTE terminates the walk; fill_ppn is the page to install
//   next     - PTE points at a level-0 table; fill_ppn is that table's PPN
//   fault    - walk must stop with a fault
//   fill_ppn - PPN to install (leaf) or to follow (next)
// Macro TLB_PTW_SUPERPAGE_EN: when defined, an aligned leaf at level 1 is
// accepted as a megapage and sliced down to the 4 KiB page being missed.
module ptw_pte_decode
    import tlb_refill_ptw_pkg::*;
(
    input  logic [31:0]          pte,
    input  logic                 level_l1,
    input  logic [VPN_WIDTH-1:0] vpn0,
    output logic                 leaf,
    output logic                 next,
    output logic                 fault,
    output logic [PPN_WIDTH-1:0] fill_ppn
);

    logic [PPN_WIDTH-1:0] pte_ppn;
    logic                 malformed;
    logic                 pointer;
    logic                 unused_pte_bits;

    assign pte_ppn = pte[PTE_PPN_MSB:PTE_PPN_LSB];

    // Invalid, reserved high bits set, or the reserved W-without-R encoding
    assign malformed = !pte[PTE_V] || (pte[31:30] != 2'b00)
                       || (pte[PTE_W] && !pte[PTE_R]);

    // R=X=0 means the PTE points at the next table level
    assign pointer = !pte[PTE_R] && !pte[PTE_X];

    // Software-defined bits and (without megapages) vpn0 are not needed
    assign unused_pte_bits = ^{pte[9:4], vpn0};

    always_comb begin
        leaf     = 1'b0;
        next     = 1'b0;
        fault    = 1'b0;
        fill_ppn = pte_ppn;
        if (malformed) begin
            fault = 1'b1;
        end else if (level_l1) begin
            if (pointer) begin
                next = 1'b1;
            end else begin
`ifdef TLB_PTW_SUPERPAGE_EN
                // A megapage must be aligned to 4 MiB; only the 4 KiB slice
                // covering the missed address is installed.
                if (pte_ppn[VPN_WIDTH-1:0] != '0) begin
                    fault = 1'b1;
                end else begin
                    leaf     = 1'b1;
                    fill_ppn = {pte_ppn[PPN_WIDTH-1:VPN_WIDTH], vpn0};
                end
`else
                fault = 1'b1;
`endif
            end
        end else begin
            // No further level exists below L0, so a pointer here is a fault
            if (pointer) begin
                fault = 1'b1;
            end else begin
                leaf = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tlb_refill_ptw.sv
// tlb_refill_ptw
// Two-level Sv32-style hardware page-table walker that refills the TLB on
// a miss, one miss at a time.
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   miss_valid/miss_vaddr/miss_ready - miss request handshake
//   root_ppn                      - page-table root, sampled at acceptance
//   mem_req/mem_addr/mem_gnt      - PTE read request (held until granted)
//   mem_rvalid/mem_rdata          - PTE read response
//   tlb_we/tlb_w_vaddr/tlb_w_paddr - one-cycle TLB write
//   refill_done/refill_fault      - one-cycle completion pulse and status
// Macro TLB_PTW_SUPERPAGE_EN enables 4 MiB megapage leaves at level 1.
module tlb_refill_ptw
    import tlb_refill_ptw_pkg::*;
#(
    parameter logic [PPN_WIDTH-1:0] ROOT_PPN_RST = 20'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        miss_valid,
    input  logic [31:0] miss_vaddr,
    output logic        miss_ready,
    input  logic [19:0] root_ppn,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        tlb_we,
    output logic [31:0] tlb_w_vaddr,
    output logic [31:0] tlb_w_paddr,
    output logic        refill_done,
    output logic        refill_fault
);

    ptw_state_e           state_q, state_d;
    logic [VPN_WIDTH-1:0] vpn1_q, vpn1_d;
    logic [VPN_WIDTH-1:0] vpn0_q, vpn0_d;
    logic [PPN_WIDTH-1:0] root_ppn_q, root_ppn_d;
    logic                 miss_ready_q, miss_ready_d;
    logic                 mem_req_q, mem_req_d;
    logic [31:0]          mem_addr_q, mem_addr_d;
    logic                 tlb_we_q, tlb_we_d;
    logic [31:0]          tlb_w_vaddr_q, tlb_w_vaddr_d;
    logic [31:0]          tlb_w_paddr_q, tlb_w_paddr_d;
    logic                 refill_done_q, refill_done_d;
    logic                 refill_fault_q, refill_fault_d;

    logic                 dec_leaf;
    logic                 dec_next;
    logic                 dec_fault;
    logic [PPN_WIDTH-1:0] dec_ppn;
    logic                 unused_offset;

    assign unused_offset = ^miss_vaddr[PAGE_OFFSET_BITS-1:0];

    ptw_pte_decode u_decode (
        .pte      (mem_rdata),
        .level_l1 (state_q == ST_L1_WAIT),
        .vpn0     (vpn0_q),
        .leaf     (dec_leaf),
        .next     (dec_next),
        .fault    (dec_fault),
        .fill_ppn (dec_ppn)
    );

    // Next-state and next-output logic. Every output is registered, so the
    // value computed here is what the outputs show while in state_d.
    always_comb begin
        state_d        = state_q;
        vpn1_d         = vpn1_q;
        vpn0_d         = vpn0_q;
        root_ppn_d     = root_ppn_q;
        mem_req_d      = mem_req_q;
        mem_addr_d     = mem_addr_q;
        tlb_we_d       = 1'b0;
        tlb_w_vaddr_d  = tlb_w_vaddr_q;
        tlb_w_paddr_d  = tlb_w_paddr_q;
        refill_done_d  = 1'b0;
        refill_fault_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (miss_valid) begin
                    vpn1_d     = miss_vaddr[31:22];
                    vpn0_d     = miss_vaddr[21:12];
                    root_ppn_d = root_ppn;
                    mem_req_d  = 1'b1;
                    mem_addr_d = {root_ppn, miss_vaddr[31:22], 2'b00};
                    state_d    = ST_L1_REQ;
                end
            end
            ST_L1_REQ: begin
                // Rebuilt from latched fields so root_ppn changes cannot leak in
                mem_addr_d = {root_ppn_q, vpn1_q, 2'b00};
                if (mem_gnt) begin
                    mem_req_d = 1'b0;
                    state_d   = ST_L1_WAIT;
                end
            end
            ST_L0_REQ: begin
                if (mem_gnt) begin
                    mem_req_d = 1'b0;
                    state_d   = ST_L0_WAIT;
                end
            end
            ST_L1_WAIT, ST_L0_WAIT: begin
                if (mem_rvalid) begin
                    if (dec_fault) begin
                        refill_done_d  = 1'b1;
                        refill_fault_d = 1'b1;
                        state_d        = ST_RESP;
                    end else if (dec_next) begin
                        mem_req_d  = 1'b1;
                        mem_addr_d = {dec_ppn, vpn0_q, 2'b00};
                        state_d    = ST_L0_REQ;
                    end else if (dec_leaf) begin
                        tlb_we_d      = 1'b1;
                        tlb_w_vaddr_d = {vpn1_q, vpn0_q, {PAGE_OFFSET_BITS{1'b0}}};
                        tlb_w_paddr_d = {dec_ppn, {PAGE_OFFSET_BITS{1'b0}}};
                        state_d       = ST_FILL;
                    end
                end
            end
            ST_FILL: begin
                refill_done_d = 1'b1;
                state_d       = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        miss_ready_d = (state_d == ST_IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            vpn1_q         <= '0;
            vpn0_q         <= '0;
            root_ppn_q     <= ROOT_PPN_RST;
            miss_ready_q   <= 1'b1;
            mem_req_q      <= 1'b0;
            mem_addr_q     <= '0;
            tlb_we_q       <= 1'b0;
            tlb_w_vaddr_q  <= '0;
            tlb_w_paddr_q  <= '0;
            refill_done_q  <= 1'b0;
            refill_fault_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            vpn1_q         <= vpn1_d;
            vpn0_q         <= vpn0_d;
            root_ppn_q     <= root_ppn_d;
            miss_ready_q   <= miss_ready_d;
            mem_req_q      <= mem_req_d;
            mem_addr_q     <= mem_addr_d;
            tlb_we_q       <= tlb_we_d;
            tlb_w_vaddr_q  <= tlb_w_vaddr_d;
            tlb_w_paddr_q  <= tlb_w_paddr_d;
            refill_done_q  <= refill_done_d;
            refill_fault_q <= refill_fault_d;
        end
    end

    // The registered ready already reflects IDLE; masking with rst keeps the
    // walker from advertising readiness while it is being held in reset.
    assign miss_ready   = miss_ready_q & ~rst;
    assign mem_req      = mem_req_q;
    assign mem_addr     = mem_addr_q;
    assign tlb_we       = tlb_we_q;
    assign tlb_w_vaddr  = tlb_w_vaddr_q;
    assign tlb_w_paddr  = tlb_w_paddr_q;
    assign refill_done  = refill_done_q;
    assign refill_fault = refill_fault_q;

endmodule

// File: tb/tb_tlb_refill_ptw.sv
// tb_tlb_refill_ptw
// Self-checking bench for tlb_refill_ptw: a vector table of walks driven
// through a small memory responder, a scoreboard of expected refills, and
// hand-written reset sequences.
module tb_tlb_refill_ptw;

    logic        clk = 1'b0;
    logic        rst;
    logic        miss_valid;
    logic [31:0] miss_vaddr;
    logic        miss_ready;
    logic [19:0] root_ppn;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        tlb_we;
    logic [31:0] tlb_w_vaddr;
    logic [31:0] tlb_w_paddr;
    logic        refill_done;
    logic        refill_fault;

    int assertCount = 0;
    int failCount   = 0;

    typedef struct {
        logic [19:0] root;
        logic [31:0] vaddr;
        logic [31:0] pte1;
        logic [31:0] pte0;
        int          d1;
        int          d0;
        bit          holdNext;
        bit          expWe;
        logic [31:0] expPaddr;
        bit          expFault;
        int          weCyc;
        int          doneCyc;
    } vec_t;

    typedef struct {
        logic [31:0] vaddr;
        logic [31:0] paddr;
        bit          fault;
        bit          we;
        int          weCyc;
        int          doneCyc;
    } exp_t;

    exp_t expQ[$];
    vec_t vecs[9];

    tlb_refill_ptw dut (
        .clk          (clk),
        .rst          (rst),
        .miss_valid   (miss_valid),
        .miss_vaddr   (miss_vaddr),
        .miss_ready   (miss_ready),
        .root_ppn     (root_ppn),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_gnt      (mem_gnt),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .tlb_we       (tlb_we),
        .tlb_w_vaddr  (tlb_w_vaddr),
        .tlb_w_paddr  (tlb_w_paddr),
        .refill_done  (refill_done),
        .refill_fault (refill_fault)
    );

    always #5 clk = ~clk;

    // Hard stop in case the stimulus itself ever wedges
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    // Runs one miss from handshake to the cycle after refill_done, acting as
    // the memory and checking every cycle. Entered and left on a negedge.
    task automatic applyStimulus(input vec_t v, input vec_t nxt);
        int          level = 1;
        int          waitCnt = 0;
        bit          pend = 0;
        bit          done = 0;
        bit          sawWe = 0;
        logic [31:0] pendData = 32'h0;
        logic [31:0] expL1;
        logic [31:0] expL0;
        string       nm;
        exp_t        e;

        expL1 = {v.root, v.vaddr[31:22], 2'b00};
        expL0 = {v.pte1[29:10], v.vaddr[21:12], 2'b00};
        e.vaddr   = {v.vaddr[31:12], 12'h000};
        e.paddr   = v.expPaddr;
        e.fault   = v.expFault;
        e.we      = v.expWe;
        e.weCyc   = v.weCyc;
        e.doneCyc = v.doneCyc;
        expQ.push_back(e);

        miss_valid = 1'b1;
        miss_vaddr = v.vaddr;
        root_ppn   = v.root;
        checkOutput("miss_ready at accept", 32'(miss_ready), 32'd1);
        if (!miss_ready) begin
            void'(expQ.pop_back());
            miss_valid = 1'b0;
            return;
        end

        for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
            @(negedge clk);
            if (v.holdNext) begin
                miss_vaddr = nxt.vaddr;
                root_ppn   = nxt.root;
            end else begin
                miss_valid = 1'b0;
            end
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            mem_rdata  = 32'hDEAD_BEEF;
            checkOutput("miss_ready while busy", 32'(miss_ready), 32'd0);

            if (pend) begin
                mem_rvalid = 1'b1;
                mem_rdata  = pendData;
                pend       = 1'b0;
            end else if (mem_req) begin
                if (level > 2) begin
                    checkOutput("extra mem_req", 32'(mem_req), 32'd0);
                end else begin
                    nm = (level == 1) ? "L1 mem_addr" : "L0 mem_addr";
                    checkOutput(nm, mem_addr, (level == 1) ? expL1 : expL0);
                    if (waitCnt < ((level == 1) ? v.d1 : v.d0)) begin
                        waitCnt++;
                    end else begin
                        mem_gnt  = 1'b1;
                        pend     = 1'b1;
                        pendData = (level == 1) ? v.pte1 : v.pte0;
                        level++;
                        waitCnt  = 0;
                    end
                end
            end

            if (tlb_we) begin
                sawWe = 1'b1;
                if (expQ.size() == 0) begin
                    checkOutput("tlb_we without expectation", 32'(tlb_we), 32'd0);
                end else begin
                    checkOutput("tlb_we cycle", 32'(cyc), 32'(expQ[0].weCyc));
                    checkOutput("tlb_w_vaddr", tlb_w_vaddr, expQ[0].vaddr);
                    checkOutput("tlb_w_paddr", tlb_w_paddr, expQ[0].paddr);
                end
            end

            if (refill_done) begin
                done = 1'b1;
                if (expQ.size() == 0) begin
                    checkOutput("refill_done without expectation", 32'(refill_done), 32'd0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("refill_done cycle", 32'(cyc), 32'(e.doneCyc));
                    checkOutput("refill_fault", 32'(refill_fault), 32'(e.fault));
                    checkOutput("tlb_we seen", 32'(sawWe), 32'(e.we));
                end
            end
        end

        if (!done) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL refill timeout: actual=no refill_done expected=refill_done");
            if (expQ.size() != 0) void'(expQ.pop_front());
        end

        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        @(negedge clk);
        checkOutput("miss_ready after done", 32'(miss_ready), 32'd1);
        checkOutput("tlb_we after done", 32'(tlb_we), 32'd0);
        checkOutput("refill_done one cycle", 32'(refill_done), 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        miss_valid = 1'b0;
        miss_vaddr = 32'h0;
        root_ppn   = 20'h0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;

        //            root      vaddr         pte1          pte0          d1 d0 hold we paddr         flt weC doneC
        vecs[0] = '{20'h00080, 32'h12345678, 32'h00020401, 32'h2AF37807, 0, 0, 0, 1, 32'hABCDE000, 0,  5, 6};
`ifdef TLB_PTW_SUPERPAGE_EN
        vecs[1] = '{20'h00080, 32'h12345678, 32'h1000000B, 32'h00000000, 0, 0, 0, 1, 32'h40345000, 0,  3, 4};
`else
        vecs[1] = '{20'h00080, 32'h12345678, 32'h1000000B, 32'h00000000, 0, 0, 0, 0, 32'h00000000, 1, -1, 3};
`endif
        vecs[2] = '{20'h00080, 32'h12345678, 32'h00000000, 32'h00000000, 0, 0, 0, 0, 32'h00000000, 1, -1, 3};
        vecs[3] = '{20'h00080, 32'h12345678, 32'h00020401, 32'h2AF37807, 3, 0, 1, 1, 32'hABCDE000, 0,  8, 9};
        vecs[4] = '{20'h00123, 32'h00401000, 32'h00000401, 32'h00000001, 0, 0, 0, 0, 32'h00000000, 1, -1, 5};
        vecs[5] = '{20'h00080, 32'h12345678, 32'h00000005, 32'h00000000, 0, 0, 0, 0, 32'h00000000, 1, -1, 3};
        vecs[6] = '{20'h00080, 32'h12345678, 32'h40000001, 32'h00000000, 0, 0, 0, 0, 32'h00000000, 1, -1, 3};
        vecs[7] = '{20'hFFFFF, 32'hFFC00ABC, 32'h00000C01, 32'h3FFFFC0F, 1, 2, 0, 1, 32'hFFFFF000, 0,  8, 9};
        vecs[8] = '{20'h00080, 32'h12345678, 32'h1000040B, 32'h00000000, 0, 0, 0, 0, 32'h00000000, 1, -1, 3};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset miss_ready", 32'(miss_ready), 32'd0);
        checkOutput("reset mem_req", 32'(mem_req), 32'd0);
        checkOutput("reset mem_addr", mem_addr, 32'd0);
        checkOutput("reset tlb_we", 32'(tlb_we), 32'd0);
        checkOutput("reset tlb_w_vaddr", tlb_w_vaddr, 32'd0);
        checkOutput("reset tlb_w_paddr", tlb_w_paddr, 32'd0);
        checkOutput("reset refill_done", 32'(refill_done), 32'd0);
        checkOutput("reset refill_fault", 32'(refill_fault), 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("miss_ready after reset", 32'(miss_ready), 32'd1);

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i], vecs[(i < 8) ? i + 1 : i]);
        end

        // Reset while waiting for the L0 PTE
        $display("[TB] reset mid-walk sequence");
        miss_valid = 1'b1;
        miss_vaddr = 32'h12345678;
        root_ppn   = 20'h00080;
        @(negedge clk);
        miss_valid = 1'b0;
        checkOutput("mid-walk L1 mem_addr", mem_addr, 32'h00080120);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h00020401;
        @(negedge clk);
        mem_rvalid = 1'b0;
        checkOutput("mid-walk L0 mem_addr", mem_addr, 32'h00081D14);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        rst     = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("abort miss_ready", 32'(miss_ready), 32'd1);
        checkOutput("abort mem_req", 32'(mem_req), 32'd0);
        checkOutput("abort mem_addr", mem_addr, 32'd0);
        checkOutput("abort tlb_we", 32'(tlb_we), 32'd0);
        checkOutput("abort tlb_w_vaddr", tlb_w_vaddr, 32'd0);
        checkOutput("abort tlb_w_paddr", tlb_w_paddr, 32'd0);
        checkOutput("abort refill_done", 32'(refill_done), 32'd0);
        checkOutput("abort refill_fault", 32'(refill_fault), 32'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h2AF37807;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            checkOutput("post-abort tlb_we", 32'(tlb_we), 32'd0);
            checkOutput("post-abort refill_done", 32'(refill_done), 32'd0);
            checkOutput("post-abort mem_req", 32'(mem_req), 32'd0);
            checkOutput("post-abort miss_ready", 32'(miss_ready), 32'd1);
        end

        checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/tlb_refill_ptw.md
# tlb_refill_ptw

Hardware page-table walker that refills the TLB on a miss. It accepts one miss at a time and performs a two-level Sv32-style walk over a 32-bit memory read port. It then writes the resulting VPN→PPN pair into the TLB's write port (`we`, `w_vaddr`, `w_paddr`) and reports completion or a fault to the requester. It sits between the TLB miss output, the memory/bus read port and the TLB maintenance interface.

## Interface

**Parameters**
- `ROOT_PPN_RST`, default `20'h0`: reset value of the internal latched root PPN, used only until the first accepted miss.

**Ports**
- `clk` input 1: clock. All logic is on the rising edge.
- `rst` input 1: reset. **Synchronous, active-high.**
- `miss_valid` input 1: miss request from the TLB lookup path.
- `miss_vaddr` input 32: faulting virtual address.
- `miss_ready` output 1: walker idle and able to accept a miss.
- `root_ppn` input 20: page-table root PPN. Sampled at miss acceptance.
- `mem_req` output 1: PTE read request.
- `mem_addr` output 32: PTE byte address, word-aligned.
- `mem_gnt` input 1: memory accepts the request this cycle.
- `mem_rvalid` input 1: read data valid.
- `mem_rdata` input 32: PTE.
- `tlb_we` output 1: TLB write strobe, one cycle wide.
- `tlb_w_vaddr` output 32: `{VPN, 12'b0}`.
- `tlb_w_paddr` output 32: `{PPN, 12'b0}`.
- `refill_done` output 1: one-cycle completion pulse.
- `refill_fault` output 1: qualifies `refill_done`; 1 means the walk failed.

## Operation

**States:** IDLE, L1_REQ, L1_WAIT, L0_REQ, L0_WAIT, FILL, RESP.

**IDLE**
- `miss_ready`=1.
- On `miss_valid && miss_ready`: latch `vpn1=miss_vaddr[31:22]`, `vpn0=miss_vaddr[21:12]`, `root_ppn`. Go to L1_REQ.

**L1_REQ / L0_REQ**
- `mem_req`=1.
- `mem_addr` = `{root_ppn, vpn1, 2'b00}` in L1_REQ, or `{pte_ppn, vpn0, 2'b00}` in L0_REQ.
- Request and address are held stable until `mem_gnt`, then go to the matching *_WAIT state.

**L1_WAIT / L0_WAIT**
- `mem_rvalid` is sampled only in these states.
- On `mem_rvalid`: decode the PTE and register the result.

**PTE decode**
- Fields: V=bit0, R=bit1, W=bit2, X=bit3, PPN=`[29:10]`.
- Fault conditions:
  - V=0
  - `[31:30]`≠0
  - W=1 with R=0
- Non-leaf: R=X=0.
- Results at L1:
  - Non-leaf: latch PPN, go to L0_REQ.
  - Leaf: superpage handling (see Configuration).
  - Fault: go to RESP with `fault`=1.
- Results at L0:
  - Leaf: fill PPN = PTE PPN, go to FILL.
  - Non-leaf: fault.

**FILL**
- `tlb_we`=1 for exactly one cycle.
- Write `tlb_w_vaddr={vpn1,vpn0,12'b0}` and `tlb_w_paddr={fill_ppn,12'b0}`.
- Go to RESP.

**RESP**
- `refill_done`=1 for one cycle, with `refill_fault` valid.
- Go to IDLE.

**Rules**
- `miss_ready`=0 in every non-IDLE state.
- A `miss_valid` arriving while busy is not accepted; the requester holds it.
- `root_ppn` changes during a walk have no effect.
- `mem_rvalid` outside the WAIT states is ignored.
- A fault never asserts `tlb_we`.

## Timing

**Reset**
- State=IDLE.
- `mem_req`, `tlb_we`, `refill_done`, `refill_fault` = 0.
- `mem_addr`, `tlb_w_vaddr`, `tlb_w_paddr` = 0.
- `miss_ready`=0 while `rst`=1, and 1 in the first cycle after.

**Reset mid-walk:** abort at the next edge and return to IDLE. No `tlb_we` and no `refill_done` follow. The memory port is reset by the same `rst`.

**Latencies** (accept handshake = cycle 0; zero-wait memory, i.e. `mem_gnt` on first request cycle and `mem_rvalid` the cycle after):
- 4 KiB walk: `tlb_we` at cycle 5, `refill_done` at cycle 6, `miss_ready` at cycle 7.
- Superpage: `tlb_we` at 3, `refill_done` at 4.
- L1 fault: `refill_done` at 3. L0 fault: `refill_done` at 5.

**Ordering**
- `tlb_we` precedes `refill_done` by exactly one cycle, so a retried lookup in the `refill_done` cycle hits.
- Each memory wait cycle (`mem_gnt` low, or `mem_rvalid` low) adds one cycle.
- The memory port never returns `mem_rvalid` in the same cycle as its `mem_gnt`.

## Configuration

Macro: `TLB_PTW_SUPERPAGE_EN`.
- **Defined:** a leaf at L1 is accepted as a 4 MiB megapage.
  - Requires PTE PPN`[9:0]`=0; otherwise fault.
  - `fill_ppn={PTE PPN[19:10], vpn0}`, i.e. a 4 KiB slice is installed.
  - Go to FILL.
- **Undefined:** any leaf at L1 is a fault.

## Structure

- Add to the shared `riscv_define.v` header:
  - PTE bit indices (`PTE_V`, `PTE_R`, `PTE_W`, `PTE_X`).
  - PTE PPN field range.
  - Walker state encodings.
- Reuse the existing `VPN_WIDTH`, `PPN_WIDTH` and `PAGE_OFFSET_BITS`.
- One combinational sub-module, `ptw_pte_decode`: inputs PTE and level; outputs leaf, next, fault, fill_ppn. The superpage macro is applied inside it.

## Test plan

1. **4 KiB walk:** `root_ppn`=0x00080, `miss_vaddr`=0x12345678.
   - Expect `mem_addr`=0x00080120; return 0x00020401.
   - Expect `mem_addr`=0x00081D14; return 0x2AF37807.
   - Expect `tlb_we` with 0x12345000→0xABCDE000 at cycle 5, then `refill_done`=1 and `refill_fault`=0 at cycle 6.
2. **Megapage:** same vaddr; L1 returns 0x1000000B.
   - With macro: `tlb_w_paddr`=0x40345000 at cycle 3, `refill_done` at 4.
   - Without macro: `refill_fault`=1 at cycle 3, no `tlb_we`.
3. **Invalid PTE:** L1 returns 0x00000000 → `refill_done` and `refill_fault` at cycle 3; `tlb_we` never asserted.
4. **Backpressure:** `mem_gnt` low for 3 cycles in L1_REQ → `mem_addr` stable at 0x00080120 throughout; `miss_ready`=0 with a second `miss_valid` held; `tlb_we` at cycle 8. The second miss is accepted the cycle after `refill_done`.
5. **Reset mid-walk:** assert `rst` for 1 cycle in L0_WAIT → next cycle IDLE with all outputs 0; a stray `mem_rvalid` is ignored; no `tlb_we`.
